// File: rtl/vend_pkg.sv
// Shared vending definitions: slot geometry, default motor time and the vend FSM states.
// Used by the inventory/dispense block and the payment stage.
package vend_pkg;

    localparam int NUM_ITEMS    = 8;
    localparam int CNT_W        = 4;
    localparam int MOTOR_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DISPENSE,
        ACK
    } state_t;

endpackage

// File: rtl/motor_timer.sv
// Motor-on down-counter: a start pulse keeps busy high for CYCLES-1 following cycles,
// so the DISPENSE state that begins with the pulse lasts exactly CYCLES cycles.
module motor_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (start)
            cnt <= LOAD;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/inventory_dispense.sv
// Per-slot stock counters and vend sequencer (IDLE/CHECK/DISPENSE/ACK) driving the dispense motor.
// Define INVENTORY_LOW_STOCK_ALERT_EN to build the low_stock comparators; otherwise low_stock is 0.
module inventory_dispense #(
    parameter int NUM_ITEMS    = vend_pkg::NUM_ITEMS,
    parameter int CNT_W        = vend_pkg::CNT_W,
    parameter int MOTOR_CYCLES = vend_pkg::MOTOR_CYCLES,
    parameter int LOW_THRESH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [NUM_ITEMS*CNT_W-1:0] init_stock,
    input  logic [3:0]                 cur_index,
    input  logic                       reduce_inventory,
    output logic                       reduce_inventory_done,
    output logic                       dispense_error,
    output logic                       motor_en,
    output logic [2:0]                 motor_sel,
    output logic [NUM_ITEMS-1:0]       sold_out,
    output logic                       empty_all,
    output logic [NUM_ITEMS-1:0]       low_stock
);

    import vend_pkg::*;

    localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    state_t                            state, next;
    logic [3:0]                        idx;
    logic [NUM_ITEMS-1:0][CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]                  sel;
    logic                              in_range, vend_ok;
    logic                              timer_start, timer_busy;
    logic                              err;

    assign sel      = idx[IDX_W-1:0];
    assign in_range = ({28'd0, idx} < 32'(NUM_ITEMS));
    // Range is qualified first so an out-of-range index never reads a counter.
    assign vend_ok  = in_range && (cnt[sel] != '0);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next        = state;
        timer_start = 1'b0;
        case (state)
            IDLE:     if (!load_en && reduce_inventory) next = CHECK;
            CHECK: begin
                if (vend_ok) begin
                    next        = DISPENSE;
                    timer_start = 1'b1;
                end else begin
                    next = ACK;
                end
            end
            DISPENSE: if (!timer_busy) next = ACK;
            ACK:      if (!reduce_inventory) next = IDLE;
            default:  next = IDLE;
        endcase
    end

    // The index is captured only on the IDLE->CHECK edge and held for the whole vend.
    always_ff @(posedge clk) begin
        if (rst)
            idx <= '0;
        else if (state == IDLE && !load_en && reduce_inventory)
            idx <= cur_index;
    end

    // Packed layout of cnt matches init_stock, so a reload is a plain copy.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && load_en))
            cnt <= init_stock;
        else if (state == CHECK && vend_ok)
            cnt[sel] <= cnt[sel] - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state == CHECK)
            err <= !vend_ok;
        else if (state == ACK && !reduce_inventory)
            err <= 1'b0;
    end

    motor_timer #(.CYCLES(MOTOR_CYCLES)) u_motor_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .busy  (timer_busy)
    );

    assign reduce_inventory_done = (state == ACK);
    assign dispense_error        = err;
    assign motor_en              = (state == DISPENSE);
    assign motor_sel             = (state == DISPENSE) ? idx[2:0] : 3'd0;

    genvar i;
    generate
        for (i = 0; i < NUM_ITEMS; i++) begin : g_flags
            assign sold_out[i] = (cnt[i] == '0);
`ifdef INVENTORY_LOW_STOCK_ALERT_EN
            assign low_stock[i] = (cnt[i] != '0) && ({{(32-CNT_W){1'b0}}, cnt[i]} <= 32'(LOW_THRESH));
`else
            assign low_stock[i] = 1'b0;
`endif
        end
    endgenerate

    assign empty_all = &sold_out;

endmodule

// File: tb/tb_inventory_dispense.sv
// Directed plus randomized vend sequences checked against a per-slot stock model.
module tb_inventory_dispense;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [31:0] init_stock;
    logic [3:0]  cur_index;
    logic        reduce_inventory;
    logic        reduce_inventory_done;
    logic        dispense_error;
    logic        motor_en;
    logic [2:0]  motor_sel;
    logic [7:0]  sold_out;
    logic        empty_all;
    logic [7:0]  low_stock;

    int total = 0;
    int bad   = 0;
    int model [8];

    inventory_dispense dut (
        .clk                   (clk),
        .rst                   (rst),
        .load_en               (load_en),
        .init_stock            (init_stock),
        .cur_index             (cur_index),
        .reduce_inventory      (reduce_inventory),
        .reduce_inventory_done (reduce_inventory_done),
        .dispense_error        (dispense_error),
        .motor_en              (motor_en),
        .motor_sel             (motor_sel),
        .sold_out              (sold_out),
        .empty_all             (empty_all),
        .low_stock             (low_stock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_stock(input int s0, s1, s2, s3, s4, s5, s6, s7);
        int v [8];
        logic [31:0] p;
        v = '{s0, s1, s2, s3, s4, s5, s6, s7};
        p = '0;
        for (int k = 0; k < 8; k++) p[k*4 +: 4] = 4'(v[k]);
        return p;
    endfunction

    function automatic void set_model(input logic [31:0] p);
        for (int k = 0; k < 8; k++) model[k] = int'(p[k*4 +: 4]);
    endfunction

    function automatic logic [7:0] exp_sold();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = (model[k] == 0);
        return r;
    endfunction

    function automatic logic [7:0] exp_low();
        logic [7:0] r;
        r = '0;
`ifdef INVENTORY_LOW_STOCK_ALERT_EN
        for (int k = 0; k < 8; k++) r[k] = (model[k] > 0) && (model[k] <= 2);
`endif
        return r;
    endfunction

    task automatic chk_flags(input string tag);
        chk({tag, ".sold_out"}, 32'(sold_out), 32'(exp_sold()));
        chk({tag, ".empty_all"}, 32'(empty_all), 32'(exp_sold() == 8'hff));
        chk({tag, ".low_stock"}, 32'(low_stock), 32'(exp_low()));
    endtask

    task automatic do_reset(input logic [31:0] stock);
        rst = 1'b1; init_stock = stock; load_en = 1'b0; reduce_inventory = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_model(stock);
        chk("rst.done", 32'(reduce_inventory_done), 0);
        chk("rst.err", 32'(dispense_error), 0);
        chk("rst.motor_en", 32'(motor_en), 0);
        chk("rst.motor_sel", 32'(motor_sel), 0);
        chk_flags("rst");
    endtask

    // One complete vend: request, watch the motor, check the ack, hold, release.
    task automatic vend(input string tag, input int idx, input int hold, input bit scramble);
        bit         ok;
        int         lat, motor, selbad, flagbad;
        logic [7:0] sold_before;
        ok = (idx < 8) && (model[idx] > 0);
        sold_before = exp_sold();
        cur_index = 4'(idx);
        reduce_inventory = 1'b1;
        lat = 0; motor = 0; selbad = 0; flagbad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            lat = c;
            if (scramble) cur_index = 4'($urandom_range(0, 15));
            if (motor_en) begin
                motor++;
                if (motor_sel != 3'(idx)) selbad++;
            end
            if (!ok && sold_out != sold_before) flagbad++;
            if (reduce_inventory_done) break;
        end
        chk({tag, ".latency"}, 32'(lat), ok ? 32'(6) : 32'(2));
        chk({tag, ".motor_cycles"}, 32'(motor), ok ? 32'(4) : 32'(0));
        chk({tag, ".motor_sel"}, 32'(selbad), 0);
        chk({tag, ".error"}, 32'(dispense_error), 32'(!ok));
        if (!ok) chk({tag, ".sold_hold"}, 32'(flagbad), 0);
        if (ok) model[idx]--;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".done_held"}, 32'(reduce_inventory_done), 1);
        end
        reduce_inventory = 1'b0;
        @(negedge clk);
        chk({tag, ".done_clr"}, 32'(reduce_inventory_done), 0);
        chk({tag, ".err_clr"}, 32'(dispense_error), 0);
        chk_flags(tag);
    endtask

    initial begin
        logic [31:0] stock;
        int          lat;
        bit          saw_motor;

        rst = 1'b1; load_en = 1'b0; reduce_inventory = 1'b0;
        cur_index = '0; init_stock = '0;
        @(negedge clk);

        // Successful vend from slot 3 with the index scrambled mid-vend.
        do_reset(pack_stock(1, 3, 0, 5, 7, 2, 9, 15));
        vend("slot3", 3, 0, 1'b1);

        // Empty slot and out-of-range index take the error path.
        vend("slot2_empty", 2, 0, 1'b0);
        vend("oor", 9, 0, 1'b0);

        // Holding the request after done must not re-vend.
        vend("hold", 4, 3, 1'b0);

        // Low-stock edge: slot 1 goes 3 -> 2 -> 1.
        vend("low1", 1, 0, 1'b0);
        vend("low2", 1, 0, 1'b0);

        // Drain slot 0 (stock 1) to check the no-wrap rule.
        vend("drain0", 0, 0, 1'b0);
        vend("drain0_again", 0, 0, 1'b0);

        // Load and vend together: reload wins, then slot 2 (now 1) is decremented.
        stock = pack_stock(4, 4, 1, 4, 4, 4, 4, 4);
        init_stock = stock; load_en = 1'b1; cur_index = 4'd2; reduce_inventory = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        set_model(stock);
        chk("loadpri.not_started", 32'(motor_en), 0);
        vend("loadpri", 2, 0, 1'b0);

        // Reset in the 2nd DISPENSE cycle.
        stock = pack_stock(2, 2, 2, 2, 2, 2, 2, 2);
        init_stock = stock;
        cur_index = 4'd5; reduce_inventory = 1'b1;
        saw_motor = 1'b0;
        repeat (3) @(negedge clk);
        saw_motor = motor_en;
        chk("rstdisp.motor_before", 32'(saw_motor), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstdisp.motor_off", 32'(motor_en), 0);
        chk("rstdisp.done", 32'(reduce_inventory_done), 0);
        rst = 1'b0; reduce_inventory = 1'b0;
        set_model(stock);
        chk_flags("rstdisp");
        vend("rstdisp.after", 5, 0, 1'b0);

        // load_en outside IDLE is ignored.
        cur_index = 4'd6; reduce_inventory = 1'b1;
        @(negedge clk);
        init_stock = '0; load_en = 1'b1;
        lat = 1;
        while (!reduce_inventory_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        load_en = 1'b0;
        chk("loadbusy.latency", 32'(lat), 6);
        model[6]--;
        reduce_inventory = 1'b0;
        @(negedge clk);
        chk_flags("loadbusy");

        // Randomized vends with occasional reloads.
        for (int r = 0; r < 40; r++) begin
            if ((r % 10) == 0) begin
                stock = $urandom;
                for (int k = 0; k < 8; k++) stock[k*4 +: 4] = 4'($urandom_range(0, 3));
                do_reset(stock);
            end
            vend("rand", int'($urandom_range(0, 9)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inventory_dispense.md
INVENTORY_DISPENSE -- requirements
Module: inventory_dispense

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 8, number of product slots.
REQ-002 SHALL have parameter CNT_W, default 4, width of each per-slot stock counter.
REQ-003 SHALL have parameter MOTOR_CYCLES, default 4, the motor-on duration per vend in clk cycles (minimum 1).
REQ-004 SHALL have parameter LOW_THRESH, default 2, the low-stock threshold (used only under REQ-027).
REQ-005 SHALL have port clk, input, 1, the clock for all state.
REQ-006 SHALL have port rst, input, 1, the reset; reset is synchronous, active-high, on clock clk.
REQ-007 SHALL have port load_en, input, 1, a restock strobe.
REQ-008 SHALL have port init_stock, input, NUM_ITEMS*CNT_W, the packed restock counts; slot i occupies bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port cur_index, input, 4, the selected slot.
REQ-010 SHALL have port reduce_inventory, input, 1, the level-held vend request from the payment stage.
REQ-011 SHALL have port reduce_inventory_done, output, 1, the vend-complete acknowledge.
REQ-012 SHALL have port dispense_error, output, 1, marking a failed vend, valid while reduce_inventory_done=1.
REQ-013 SHALL have port motor_en, output, 1, the dispense motor drive.
REQ-014 SHALL have port motor_sel, output, 3, the slot being driven.
REQ-015 SHALL have port sold_out, output, NUM_ITEMS, per-slot flags; bit i=1 when count[i]==0.
REQ-016 SHALL have port empty_all, output, 1, set when every slot count is 0.
REQ-017 SHALL have port low_stock, output, NUM_ITEMS, per-slot low-stock alert flags.

Function
REQ-018 SHALL implement FSM states IDLE, CHECK, DISPENSE and ACK.
- IDLE: reduce_inventory=1 -> CHECK; the slot index is latched.
- CHECK: latched index >= NUM_ITEMS or count==0 -> ACK with error=1; otherwise -> DISPENSE, count decremented by 1 on this edge.
- DISPENSE: motor_en=1 and motor_sel=latched index for exactly MOTOR_CYCLES cycles -> ACK.
- ACK: reduce_inventory_done=1, held until reduce_inventory is sampled 0 -> IDLE; done and error clear on that same edge.
REQ-019 SHALL produce latency, reduce_inventory rise to done=1: MOTOR_CYCLES+2 cycles on success, 2 cycles on error.
REQ-020 SHALL latch the index in IDLE; cur_index changes after that SHALL NOT affect the vend in progress.
REQ-021 SHALL never let a stock counter wrap below 0; a vend from count 0 SHALL take the error path with no decrement and no motor.
REQ-022 SHALL, when load_en=1 in IDLE, load all counts from init_stock; load_en in any other state SHALL be ignored.
REQ-023 SHALL give load priority when load_en and reduce_inventory are both 1 in IDLE: stay in IDLE that cycle and accept the vend on the next cycle while it remains asserted.
REQ-024 SHALL derive sold_out, empty_all and low_stock combinationally from the registered counts.

Reset
REQ-025 SHALL, while rst=1, force the FSM to IDLE, load counts from init_stock, and set done=0, error=0, motor_en=0, motor_sel=0 and the motor timer to 0.
REQ-026 SHALL, on rst during DISPENSE, drop motor_en on the next edge; the already-applied decrement SHALL be overwritten by the reload.

Configuration
REQ-027 SHALL support macro INVENTORY_LOW_STOCK_ALERT_EN:
- Defined: low_stock[i]=1 when 0 < count[i] <= LOW_THRESH.
- Undefined: low_stock SHALL be tied to all zeros and no comparators synthesized.

Structure
REQ-028 SHALL place NUM_ITEMS, CNT_W, the default MOTOR_CYCLES and the FSM state typedef in shared package vend_pkg, shared with the payment stage.
REQ-029 SHALL implement the MOTOR_CYCLES down-counter as sub-module motor_timer (inputs start, rst; output busy).

Verification
REQ-030 Scenario: reset with slot 3 stock 5; cur_index=3, reduce_inventory=1 -> motor_en=1 for 4 cycles with motor_sel=3, done at cycle 6, error=0, count[3]=4.
REQ-031 Scenario: slot 2 stock 0, vend request -> done at cycle 2, error=1, motor_en never 1, sold_out[2]=1 throughout.
REQ-032 Scenario: hold reduce_inventory high for 3 cycles after done -> done stays 1; deassert -> done=0 next edge; exactly one decrement.
REQ-033 Scenario: load_en and reduce_inventory both 1 in IDLE -> counts reloaded first; the vend then decrements the reloaded value.
REQ-034 Scenario: rst asserted in the 2nd DISPENSE cycle -> motor_en=0 next edge, FSM IDLE, counts equal init_stock.
REQ-035 Scenario: macro defined, slot 1 stock 3, two vends -> low_stock[1] goes 0 -> 1 after the first vend; macro undefined -> low_stock stays 0.
